// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexes four 8-bit active-low digit patterns onto one shared cathode
// bus with a one-cold anode select for a 4-digit common-anode display.
// All four patterns are captured together once per frame into shadow
// registers, and each digit slot opens with a blanking gap to avoid ghosting.
//
// Optional feature: define SEG_SCAN_DIMMING_EN to add a 4-bit brightness
// input and a per-slot PWM that gates the DRIVE phase.
//
// Timing model: an/cath/frameTick are registered from the *next* counter
// values, so the outputs seen in a cycle always match the slot counter and
// digit index held in that same cycle.

module seg_scan_driver #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       Clk100M,
    input  logic       reset,
`ifdef SEG_SCAN_DIMMING_EN
    input  logic [3:0] brightness,
`endif
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    output logic [3:0] an,
    output logic [7:0] cath,
    output logic       frameTick
);

    localparam int SW = $clog2(CLK_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_q,    digit_d;
    logic [7:0]    shadow_q [4];
    logic [7:0]    shadow_d [4];
    logic [3:0]    an_q,       an_d;
    logic [7:0]    cath_q,     cath_d;
    logic          frame_tick_q, frame_tick_d;

    logic [7:0]    seg_in [4];
    logic          slot_wrap;
    logic          frame_end;
    logic          in_drive_d;
    logic          pix_on_d;

    assign seg_in[0] = seg0;
    assign seg_in[1] = seg1;
    assign seg_in[2] = seg2;
    assign seg_in[3] = seg3;

    // Last cycle of a slot, and last cycle of the whole 4-slot frame.
    assign slot_wrap = (slot_cnt_q == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_q == 2'd3);

    // Slot counter wraps every CLK_DIV cycles; digit index steps on each wrap.
    always_comb begin
        slot_cnt_d = slot_cnt_q + SW'(1);
        digit_d    = digit_q;
        if (slot_wrap) begin
            slot_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    // Shadow registers reload as a set at the frame boundary only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        frame_tick_d = frame_end;
        if (frame_end) begin
            for (int i = 0; i < 4; i++) begin
                shadow_d[i] = seg_in[i];
            end
        end
    end

    // DRIVE phase decode for the upcoming cycle; with no blanking every
    // cycle of the slot drives.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_drive_d = 1'b1;
    end else begin : g_blank
        localparam logic [SW-1:0] BLANK_W = SW'(BLANK_CYCLES);
        assign in_drive_d = (slot_cnt_d >= BLANK_W);
    end

`ifdef SEG_SCAN_DIMMING_EN
    logic [3:0] pwm_q,    pwm_d;
    logic [3:0] bright_q, bright_d;

    // PWM restarts at the first DRIVE cycle of a slot and holds at zero
    // while blanked; brightness is only taken in alongside the shadows.
    always_comb begin
        bright_d = bright_q;
        if (frame_end) begin
            bright_d = brightness;
        end
        pwm_d = pwm_q + 4'd1;
        if (!in_drive_d || (slot_cnt_d == SW'(BLANK_CYCLES))) begin
            pwm_d = 4'd0;
        end
        pix_on_d = in_drive_d && (pwm_d < bright_d);
    end

    // PWM and brightness registers.
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            pwm_q    <= 4'd0;
            bright_q <= 4'd0;
        end else begin
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
        end
    end
`else
    assign pix_on_d = in_drive_d;
`endif

    // Output decode: anode and cathode switch in the same cycle, so a digit
    // change is always preceded (or replaced) by both buses going dark.
    always_comb begin
        an_d   = 4'hF;
        cath_d = 8'hFF;
        if (pix_on_d) begin
            an_d   = ~(4'b0001 << digit_d);
            cath_d = shadow_d[digit_d];
        end
    end

    // State register; reset blanks the display and drops all scan progress.
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            digit_q      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 8'hFF;
            end
            an_q         <= 4'hF;
            cath_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            an_q         <= an_d;
            cath_q       <= cath_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an        = an_q;
    assign cath      = cath_q;
    assign frameTick = frame_tick_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Physical-side consumer of the four 8-bit segment buses (seg0..seg3) produced by the game's display control path.
- Time-multiplexes those four digit patterns onto one shared 8-bit cathode bus and a 4-bit anode select for the board's 4-digit common-anode display.
- Captures all four patterns once per full frame into shadow registers, so a frame never mixes old and new digits.
- Inserts a blanking gap at every digit switch to suppress ghosting.

Parameters:
- CLK_DIV, 100000, Clk100M cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off; must satisfy 0 <= BLANK_CYCLES < CLK_DIV.

Ports:
- Clk100M  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- seg0  input  8  digit 0 (rightmost) pattern; active-low; bit7 = DP, bits6..0 = g..a.
- seg1  input  8  digit 1 pattern, same encoding.
- seg2  input  8  digit 2 pattern, same encoding.
- seg3  input  8  digit 3 (leftmost) pattern, same encoding.
- an  output  4  anode enables, active-low, one-hot-low when driving; an[i] selects digit i.
- cath  output  8  shared cathode bus, active-low.
- frameTick  output  1  one-cycle pulse when the shadow registers reload (frame boundary).

Behaviour:
- Single clock (Clk100M). Reset is synchronous, active-high, named reset. Reset has priority over all other activity.
- State under reset:
  - slotCnt = 0, digit = 0.
  - All four shadow registers = 8'hFF.
  - an = 4'hF, cath = 8'hFF, frameTick = 0.
- slotCnt is ceil(log2(CLK_DIV)) bits wide.
  - It increments every cycle and wraps from CLK_DIV-1 to 0.
  - On that wrap, digit (2 bits) increments modulo 4: 0→1→2→3→0.
- Shadow reload:
  - On the edge where slotCnt = CLK_DIV-1 and digit = 3, shadow[i] <= seg_i for all i, all in the same cycle.
  - frameTick is registered high for the following cycle only.
  - Input changes at any other time are ignored until the next reload.
- Per-slot phases (an/cath are registered and reflect the slotCnt/digit value held during that same cycle):
  - BLANK phase, slotCnt < BLANK_CYCLES: an = 4'hF, cath = 8'hFF.
  - DRIVE phase, slotCnt >= BLANK_CYCLES: an = ~(4'b0001 << digit), cath = shadow[digit].
  - With BLANK_CYCLES = 0 there is no BLANK phase; slots drive back to back.
- Safety rules:
  - an never has more than one bit low in any cycle, including the reset-release cycle.
  - an and cath never change in different cycles at a digit switch; both go blank together.
- Startup: the first frame after reset displays blank (shadows = FF). The first real content appears in the frame following the first frameTick, 4*CLK_DIV cycles after reset deasserts.
- Reset asserted mid-slot: on the next edge, outputs go blank and counters return to 0. No partial-slot or partial-frame state survives.
- Frame period is 4*CLK_DIV cycles. Duty per digit is (CLK_DIV-BLANK_CYCLES)/(4*CLK_DIV).

Optional Feature:
- Macro: SEG_SCAN_DIMMING_EN.
- When defined:
  - Add input port brightness [3:0].
  - A 4-bit PWM counter (pwmCnt) advances once per cycle during the DRIVE phase.
  - Within DRIVE, the digit is enabled only while pwmCnt < brightness. Otherwise an = 4'hF and cath = 8'hFF.
  - brightness = 0 gives permanently blank; brightness = 15 gives 15/16 on-time.
  - brightness is sampled together with the shadow reload only.
  - pwmCnt resets to 0 on reset and at every slot start.
- When not defined: no brightness port and no PWM logic. DRIVE is always fully on.

Test Plan:
1. CLK_DIV=8, BLANK_CYCLES=2; hold reset 3 cycles, then seg0..3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0 -> frameTick first pulses at cycle 32 after release. During cycles 34..39: an=4'b1110, cath=8'hC0. During cycles 42..47: an=4'b1101, cath=8'hF9.
2. Change seg2 from 8'hA4 to 8'h92 in the middle of a frame -> the current frame still shows A4 on digit 2. The next frame (after frameTick) shows 8'h92.
3. Slot boundaries -> every cycle with slotCnt in {0,1}: an=4'hF, cath=8'hFF. Assert an is never zero-hot-low-multiple (popcount of ~an <= 1) over 1000 cycles.
4. Assert reset at slotCnt=5 of digit 2 -> next cycle an=4'hF, cath=8'hFF, frameTick=0. After release, the scan restarts at digit 0 and the first frame is blank.
5. BLANK_CYCLES=0, CLK_DIV=4 -> no blank cycles. The an sequence is 1110 x4, 1101 x4, 1011 x4, 0111 x4, repeating.
6. With SEG_SCAN_DIMMING_EN, CLK_DIV=40, BLANK_CYCLES=8, brightness=4 -> each DRIVE phase shows exactly 8 active cycles (2 PWM periods x 4). brightness=0 -> an stays 4'hF throughout.
